// File: rtl/ifetch_unit_if.sv
// Instruction-memory fetch bus between ifetch_unit (master) and imem (slave).
// imem_req/imem_addr stay stable until imem_ack; imem_rdata is valid in the ack cycle.
interface ifetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_unit.sv
// Minisys-1A instruction fetch stage with IF/ID pipeline register.
// Owns the PC, runs a variable-latency req/ack fetch to imem, and steers the
// PC from the decode-stage redirect controls (nBranch, Wpc, rs_data).
// Optional macro IFETCH_PERF_EN adds fetch and redirect performance counters.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | one cycle after reset release, no request
// S_REQ     | request outstanding at imem_addr == pc
// S_HOLD    | word acked while decode stalled, parked in buf_q, no request
// S_DISCARD | wrong-path request still outstanding; its data will be dropped
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clock,
    input  logic                reset_n,
    ifetch_unit_if.master       imem,
    input  logic                ID_stall,
    input  logic [1:0]          Wpc,
    input  logic                nBranch,
    input  logic                IF_flush,
    input  logic [31:0]         rs_data,
    output logic [31:0]         IF_ID_instr,
    output logic [5:0]          IF_ID_op,
    output logic [31:0]         IF_ID_pc_plus4,
    output logic                IF_ID_valid,
`ifdef IFETCH_PERF_EN
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_flush_cnt,
`endif
    output logic [31:0]         pc_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HOLD    = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic [31:0] buf_q;
    logic [31:0] instr_q;
    logic [31:0] pc4_q;
    logic        valid_q;

    logic        redirect;
    logic        squash;
    logic [31:0] target;
    logic [31:0] pc_plus4;
    logic [31:0] br_off;

    // Redirect detection and target selection; nBranch outranks Wpc.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        redirect = valid_q & ~ID_stall & (nBranch | (Wpc != 2'b00));
        // IF_flush only qualifies a squash that a redirect already implies.
        squash   = redirect | (redirect & IF_flush);
        target   = pc4_q;
        if (!nBranch) begin
            case (Wpc)
                2'b01:   target = pc4_q + br_off;
                2'b10:   target = {pc4_q[31:28], instr_q[25:0], 2'b00};
                2'b11:   target = rs_data & 32'hFFFF_FFFC;
                default: target = pc4_q;
            endcase
        end
    end

    // Fetch FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            addr_q  <= {RESET_PC[31:2], 2'b00};
            req_q   <= 1'b0;
            buf_q   <= NOP_INSTR;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else if (ID_stall) begin
            // IF/ID and pc frozen; the bus side still makes progress.
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                S_REQ: begin
                    if (imem.imem_ack) begin
                        buf_q   <= imem.imem_rdata;
                        req_q   <= 1'b0;
                        state_q <= S_HOLD;
                    end
                end
                S_DISCARD: begin
                    if (imem.imem_ack) begin
                        addr_q  <= pc_q;
                        state_q <= S_REQ;
                    end
                end
                default: ;
            endcase
        end else if (squash) begin
            pc_q    <= target;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            if ((state_q == S_REQ || state_q == S_DISCARD) && !imem.imem_ack) begin
                // Keep the outstanding request stable; its data is wrong-path.
                state_q <= S_DISCARD;
            end else begin
                state_q <= S_REQ;
                req_q   <= 1'b1;
                addr_q  <= target;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                S_REQ: begin
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        pc4_q   <= pc_plus4;
                        valid_q <= 1'b1;
                        pc_q    <= pc_plus4;
                        addr_q  <= pc_plus4;
                    end else begin
                        instr_q <= NOP_INSTR;
                        valid_q <= 1'b0;
                    end
                end
                S_HOLD: begin
                    instr_q <= buf_q;
                    pc4_q   <= pc_plus4;
                    valid_q <= 1'b1;
                    pc_q    <= pc_plus4;
                    addr_q  <= pc_plus4;
                    req_q   <= 1'b1;
                    state_q <= S_REQ;
                end
                S_DISCARD: begin
                    instr_q <= NOP_INSTR;
                    valid_q <= 1'b0;
                    if (imem.imem_ack) begin
                        addr_q  <= pc_q;
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic        fetch_wr;
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;

    // A valid instruction enters IF/ID from the bus or from the skid buffer.
    always_comb begin
        fetch_wr = ~ID_stall & ~redirect &
                   (((state_q == S_REQ) & imem.imem_ack) | (state_q == S_HOLD));
    end

    // Free-running performance counters, wrapping at 2^32.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
        end else begin
            if (fetch_wr) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (redirect) flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif

    assign imem.imem_req   = req_q;
    assign imem.imem_addr  = addr_q;
    assign IF_ID_instr     = instr_q;
    assign IF_ID_op        = instr_q[31:26];
    assign IF_ID_pc_plus4  = pc4_q;
    assign IF_ID_valid     = valid_q;
    assign pc_out          = pc_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed-vector bench for ifetch_unit: sequential fetch, ack latency,
// stall/skid buffer, branch/jump/jr redirects, PC wrap and mid-request reset.
module tb_ifetch_unit;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        ID_stall;
    logic [1:0]  Wpc;
    logic        nBranch;
    logic        IF_flush;
    logic [31:0] rs_data;
    logic        ack_drv;
    logic        echo;
    logic [31:0] rdata_drv;
    logic [31:0] IF_ID_instr;
    logic [5:0]  IF_ID_op;
    logic [31:0] IF_ID_pc_plus4;
    logic        IF_ID_valid;
    logic [31:0] pc_out;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int passed = 0;
    int total  = 0;

    ifetch_unit_if bus ();

    assign bus.imem_ack   = ack_drv;
    assign bus.imem_rdata = echo ? bus.imem_addr : rdata_drv;

    ifetch_unit dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .imem           (bus),
        .ID_stall       (ID_stall),
        .Wpc            (Wpc),
        .nBranch        (nBranch),
        .IF_flush       (IF_flush),
        .rs_data        (rs_data),
        .IF_ID_instr    (IF_ID_instr),
        .IF_ID_op       (IF_ID_op),
        .IF_ID_pc_plus4 (IF_ID_pc_plus4),
        .IF_ID_valid    (IF_ID_valid),
`ifdef IFETCH_PERF_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .pc_out         (pc_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        reset_n   = 1'b0;
        ID_stall  = 1'b0;
        Wpc       = 2'b00;
        nBranch   = 1'b0;
        IF_flush  = 1'b0;
        rs_data   = 32'h0;
        ack_drv   = 1'b0;
        echo      = 1'b0;
        rdata_drv = 32'h0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("rst_addr",  bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("rst_instr", IF_ID_instr, 32'h0);
        chk("rst_pc4",   IF_ID_pc_plus4, 32'h0);
        chk("rst_pc",    pc_out, 32'h0);

        // Zero-latency imem, rdata mirrors the address.
        reset_n = 1'b1; ack_drv = 1'b1; echo = 1'b1;
        tick();
        chk("seq1_req",   {31'b0, bus.imem_req}, 32'h1);
        chk("seq1_addr",  bus.imem_addr, 32'h0);
        chk("seq1_valid", {31'b0, IF_ID_valid}, 32'h0);
        tick();
        chk("seq2_addr",  bus.imem_addr, 32'h4);
        chk("seq2_pc4",   IF_ID_pc_plus4, 32'h4);
        chk("seq2_valid", {31'b0, IF_ID_valid}, 32'h1);
        chk("seq2_instr", IF_ID_instr, 32'h0);
        IF_flush = 1'b1;
        tick();
        chk("seq3_addr",  bus.imem_addr, 32'h8);
        chk("seq3_pc4",   IF_ID_pc_plus4, 32'h8);
        chk("seq3_instr", IF_ID_instr, 32'h4);
        chk("flush_alone_valid", {31'b0, IF_ID_valid}, 32'h1);
        IF_flush = 1'b0;
        tick();
        chk("seq4_addr",  bus.imem_addr, 32'hC);
        chk("seq4_pc4",   IF_ID_pc_plus4, 32'hC);
        chk("seq4_instr", IF_ID_instr, 32'h8);

        // Two-cycle ack latency.
        ack_drv = 1'b0;
        tick();
        chk("lat1_req",   {31'b0, bus.imem_req}, 32'h1);
        chk("lat1_addr",  bus.imem_addr, 32'hC);
        chk("lat1_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("lat1_instr", IF_ID_instr, 32'h0);
        tick();
        chk("lat2_addr",  bus.imem_addr, 32'hC);
        chk("lat2_valid", {31'b0, IF_ID_valid}, 32'h0);
        ack_drv = 1'b1;
        tick();
        chk("lat3_instr", IF_ID_instr, 32'hC);
        chk("lat3_pc4",   IF_ID_pc_plus4, 32'h10);
        chk("lat3_valid", {31'b0, IF_ID_valid}, 32'h1);
        chk("lat3_addr",  bus.imem_addr, 32'h10);

        // Stall in the ack cycle: word parked (a j to 0x100), later acks ignored.
        echo = 1'b0; rdata_drv = 32'h0800_0040; ID_stall = 1'b1;
        tick();
        chk("hold1_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("hold1_instr", IF_ID_instr, 32'hC);
        chk("hold1_pc4",   IF_ID_pc_plus4, 32'h10);
        chk("hold1_pc",    pc_out, 32'h10);
        rdata_drv = 32'hBAD0_BAD0;
        tick();
        chk("hold2_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("hold2_instr", IF_ID_instr, 32'hC);
        tick();
        chk("hold3_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("hold3_valid", {31'b0, IF_ID_valid}, 32'h1);
        ID_stall = 1'b0;
        tick();
        chk("rel_instr", IF_ID_instr, 32'h0800_0040);
        chk("rel_op",    {26'b0, IF_ID_op}, 32'h2);
        chk("rel_pc4",   IF_ID_pc_plus4, 32'h14);
        chk("rel_addr",  bus.imem_addr, 32'h14);
        chk("rel_req",   {31'b0, bus.imem_req}, 32'h1);

        // Jump with request outstanding -> wrong-path request kept until ack.
        ack_drv = 1'b0; Wpc = 2'b10;
        tick();
        chk("j_pc",    pc_out, 32'h100);
        chk("j_addr",  bus.imem_addr, 32'h14);
        chk("j_req",   {31'b0, bus.imem_req}, 32'h1);
        chk("j_valid", {31'b0, IF_ID_valid}, 32'h0);
        Wpc = 2'b00; ack_drv = 1'b1; rdata_drv = 32'h1111_1111;
        tick();
        chk("jd_addr",  bus.imem_addr, 32'h100);
        chk("jd_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("jd_instr", IF_ID_instr, 32'h0);

        // beq at 0x100, imm 0xFFFE: taken to 0xFC, then nBranch back to 0x104.
        rdata_drv = 32'h1000_FFFE;
        tick();
        chk("beq_pc4",   IF_ID_pc_plus4, 32'h104);
        chk("beq_op",    {26'b0, IF_ID_op}, 32'h4);
        chk("beq_valid", {31'b0, IF_ID_valid}, 32'h1);
        chk("beq_addr",  bus.imem_addr, 32'h104);
        Wpc = 2'b01; rdata_drv = 32'h2222_2222;
        tick();
        chk("br_addr",  bus.imem_addr, 32'hFC);
        chk("br_pc",    pc_out, 32'hFC);
        chk("br_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("br_instr", IF_ID_instr, 32'h0);
        Wpc = 2'b00; rdata_drv = 32'h0;
        tick();
        chk("br_next_pc4",   IF_ID_pc_plus4, 32'h100);
        chk("br_next_valid", {31'b0, IF_ID_valid}, 32'h1);
        chk("br_next_addr",  bus.imem_addr, 32'h100);
        rdata_drv = 32'h1000_FFFE;
        tick();
        chk("beq2_pc4",  IF_ID_pc_plus4, 32'h104);
        chk("beq2_addr", bus.imem_addr, 32'h104);
        nBranch = 1'b1; Wpc = 2'b01; rdata_drv = 32'h3333_3333;
        tick();
        chk("nb_addr",  bus.imem_addr, 32'h104);
        chk("nb_pc",    pc_out, 32'h104);
        chk("nb_valid", {31'b0, IF_ID_valid}, 32'h0);

        // jr to 0x1003 with request outstanding -> DISCARD, late data dropped.
        nBranch = 1'b0; Wpc = 2'b00; rdata_drv = 32'h0020_0008;
        tick();
        chk("jr_instr", IF_ID_instr, 32'h0020_0008);
        chk("jr_pc4",   IF_ID_pc_plus4, 32'h108);
        chk("jr_addr",  bus.imem_addr, 32'h108);
        ack_drv = 1'b0; Wpc = 2'b11; rs_data = 32'h0000_1003;
        tick();
        chk("jr_pc",    pc_out, 32'h1000);
        chk("jr_daddr", bus.imem_addr, 32'h108);
        chk("jr_dreq",  {31'b0, bus.imem_req}, 32'h1);
        chk("jr_valid", {31'b0, IF_ID_valid}, 32'h0);
        Wpc = 2'b00;
        tick();
        chk("disc_addr",  bus.imem_addr, 32'h108);
        chk("disc_valid", {31'b0, IF_ID_valid}, 32'h0);
        ack_drv = 1'b1; rdata_drv = 32'h4444_4444;
        tick();
        chk("disc_ack_addr",  bus.imem_addr, 32'h1000);
        chk("disc_ack_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("disc_ack_instr", IF_ID_instr, 32'h0);
        ack_drv = 1'b0;
        tick();
        chk("disc_after_instr", IF_ID_instr, 32'h0);
        chk("disc_after_addr",  bus.imem_addr, 32'h1000);

        // jr to 0xFFFF_FFFF -> 0xFFFF_FFFC, then sequential wrap to 0.
        ack_drv = 1'b1; rdata_drv = 32'h0020_0008;
        tick();
        chk("jr2_pc4", IF_ID_pc_plus4, 32'h1004);
        Wpc = 2'b11; rs_data = 32'hFFFF_FFFF; rdata_drv = 32'h5555_5555;
        tick();
        chk("wrap_addr",  bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_valid", {31'b0, IF_ID_valid}, 32'h0);
        Wpc = 2'b00; rdata_drv = 32'h6666_6666;
        tick();
        chk("wrap_next_addr",  bus.imem_addr, 32'h0);
        chk("wrap_next_pc4",   IF_ID_pc_plus4, 32'h0);
        chk("wrap_next_instr", IF_ID_instr, 32'h6666_6666);
        ack_drv = 1'b0;
        tick();
        chk("wait_req", {31'b0, bus.imem_req}, 32'h1);

        // Reset mid-wait, then a late ack while coming out of reset.
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_req",   {31'b0, bus.imem_req}, 32'h0);
        chk("mrst_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("mrst_pc",    pc_out, 32'h0);
        ack_drv = 1'b1; rdata_drv = 32'h7777_7777;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        chk("late_ack_valid", {31'b0, IF_ID_valid}, 32'h0);
        chk("late_ack_req",   {31'b0, bus.imem_req}, 32'h1);
        chk("late_ack_addr",  bus.imem_addr, 32'h0);
        tick();
        chk("post_rst_instr", IF_ID_instr, 32'h7777_7777);
        chk("post_rst_pc4",   IF_ID_pc_plus4, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
